// File: rtl/speaker_cue_pkg.sv
// Shared types and helpers for the speaker cue sequencer and its timing blocks.
`timescale 1ns/1ps
package speaker_cue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        PLAY,
        RAMP_DOWN
    } cue_state_e;

    localparam int unsigned MAX_CH = 32;

    function automatic int unsigned vol_max(input int unsigned vol_w);
        return (32'd1 << vol_w) - 32'd1;
    endfunction

    // Code 0 is silence; code i selects channel i-1.
    function automatic logic [MAX_CH-1:0] code_to_onehot(input int unsigned code);
        logic [MAX_CH-1:0] oh;
        oh = '0;
        if (code != 0 && code <= MAX_CH)
            oh = MAX_CH'(1) << (code - 1);
        return oh;
    endfunction

endpackage

// File: rtl/speaker_cue_ctl_ramp_tick.sv
// Prescaler producing one tick every RAMP_DIV enabled cycles; clr restarts the count.
`timescale 1ns/1ps
module ramp_tick #(
    parameter int unsigned RAMP_DIV = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/speaker_cue_ctl.sv
// Game-state to melody-channel sequencer: volume ramps, sequential crossfade,
// restart pulses and per-channel loop/one-shot handling.
`timescale 1ns/1ps
module speaker_cue_ctl
    import speaker_cue_pkg::*;
#(
    parameter int unsigned         N_STATES  = 4,
    parameter int unsigned         STATE_W   = $clog2(N_STATES),
    parameter int unsigned         VOL_W     = 4,
    parameter int unsigned         RAMP_DIV  = 1024,
    parameter logic [N_STATES-2:0] LOOP_MASK = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STATE_W-1:0]  state,
    input  logic                song_done,
    output logic [N_STATES-2:0] chan_en,
    output logic [VOL_W-1:0]    vol,
    output logic                restart,
    output logic                busy
);

    localparam int unsigned        N_CH     = N_STATES - 1;
    localparam logic [VOL_W-1:0]   VOL_MAX  = VOL_W'(vol_max(VOL_W));
    localparam logic [STATE_W:0]   N_CODES  = (STATE_W + 1)'(N_STATES);
    localparam logic [MAX_CH-1:0]  LOOP_EXT = MAX_CH'(LOOP_MASK);

    cue_state_e         fsm, fsm_d;
    logic [STATE_W-1:0] tgt_q, tgt_d, cur, cur_d, lock, lock_d;
    logic [VOL_W-1:0]   vol_d;
    logic [N_CH-1:0]    chan_en_d;
    logic               restart_d, busy_d;
    logic               tick, in_ramp, ramp_entry, loop_cur;

    assign tgt_d    = ({1'b0, state} >= N_CODES) ? '0 : state;
    assign in_ramp  = (fsm == RAMP_UP) || (fsm == RAMP_DOWN);
    assign loop_cur = |(LOOP_EXT & code_to_onehot(32'(cur)));

    ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (ramp_entry),
        .en   (in_ramp),
        .tick (tick)
    );

    always_comb begin
        fsm_d     = fsm;
        cur_d     = cur;
        vol_d     = vol;
        restart_d = 1'b0;
        lock_d    = (tgt_q != lock) ? '0 : lock;

        case (fsm)
            IDLE: begin
                vol_d = '0;
                cur_d = '0;
                if (tgt_q != '0 && tgt_q != lock) begin
                    cur_d     = tgt_q;
                    restart_d = 1'b1;
                    fsm_d     = RAMP_UP;
                end
            end
            RAMP_UP: begin
                // A reversal wins over a coincident tick so the fade-out starts at the held level.
                if (tgt_q != cur)
                    fsm_d = RAMP_DOWN;
                else if (vol == VOL_MAX)
                    fsm_d = PLAY;
                else if (tick) begin
                    vol_d = vol + 1'b1;
                    if (vol_d == VOL_MAX)
                        fsm_d = PLAY;
                end
            end
            PLAY: begin
                vol_d = VOL_MAX;
                if (tgt_q != cur)
                    fsm_d = RAMP_DOWN;
                else if (song_done && loop_cur)
                    restart_d = 1'b1;
                else if (song_done) begin
                    lock_d = cur;
                    fsm_d  = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (vol == '0) begin
                    cur_d = '0;
                    fsm_d = IDLE;
                end else if (tick) begin
                    vol_d = vol - 1'b1;
                    if (vol_d == '0) begin
                        cur_d = '0;
                        fsm_d = IDLE;
                    end
                end
            end
        endcase

        ramp_entry = ((fsm_d == RAMP_UP) || (fsm_d == RAMP_DOWN)) && (fsm_d != fsm);
        busy_d     = (fsm_d == RAMP_UP) || (fsm_d == RAMP_DOWN);
        chan_en_d  = (fsm_d != IDLE) ? N_CH'(code_to_onehot(32'(cur_d))) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            tgt_q   <= '0;
            cur     <= '0;
            lock    <= '0;
            vol     <= '0;
            chan_en <= '0;
            restart <= 1'b0;
            busy    <= 1'b0;
        end else begin
            fsm     <= fsm_d;
            tgt_q   <= tgt_d;
            cur     <= cur_d;
            lock    <= lock_d;
            vol     <= vol_d;
            chan_en <= chan_en_d;
            restart <= restart_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: doc/speaker_cue_ctl.md
Name: speaker_cue_ctl

Overview:
Sequenced successor to the combinational game-state decoder that drives the speaker melody players. It maps a game-state code to a one-hot channel enable, as before (state 0 = silence, state i = channel i-1). It adds volume ramping, crossfade-by-sequence on state change, melody restart pulses, and per-channel loop/one-shot modes. It sits between the game FSM and the melody/PWM generators.

Parameters:
N_STATES, 4, number of game-state codes incl. silence; channels = N_STATES-1 (min 2)
STATE_W, $clog2(N_STATES), width of state input
VOL_W, 4, volume width; VOL_MAX = 2**VOL_W-1
RAMP_DIV, 1024, clk cycles per one-step volume change (>=1)
LOOP_MASK, all ones, bit i=1: channel i loops on song_done; bit i=0: one-shot

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
state  in  STATE_W  game state code; values >= N_STATES treated as 0
song_done  in  1  one-cycle pulse from active melody player at end of song
chan_en  out  N_STATES-1  one-hot enable of active channel; all zero when silent
vol  out  VOL_W  current volume to PWM stage
restart  out  1  one-cycle pulse: melody pointer of chan_en channel to start
busy  out  1  high in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset is synchronous on clk. While rst is high and on the first cycle after: FSM=IDLE, chan_en=0, vol=0, restart=0, busy=0, cur=0, lock=0, prescaler=0.
- state is registered into tgt_q every cycle. The FSM acts on tgt_q, so reaction is 2 edges after a state change. All outputs are registered.
- tick: the prescaler counts 0..RAMP_DIV-1 only in ramp states and clears on entry to any ramp state. tick=1 when count==RAMP_DIV-1. With RAMP_DIV=1, tick fires every ramp cycle.
- IDLE: vol=0, chan_en=0.
  - If tgt_q!=0 and tgt_q!=lock: cur<=tgt_q, restart pulses, go to RAMP_UP.
- RAMP_UP: vol+1 per tick. When vol reaches VOL_MAX, go to PLAY.
  - If tgt_q!=cur: go to RAMP_DOWN from the current vol, with no jump.
- PLAY: vol held at VOL_MAX.
  - tgt_q!=cur: go to RAMP_DOWN.
  - Else if song_done and LOOP_MASK[cur-1]=1: restart pulses, stay in PLAY.
  - Else if song_done and one-shot: lock<=cur, go to RAMP_DOWN.
- RAMP_DOWN: vol-1 per tick. When vol==0: cur<=0, go to IDLE.
  - A target change does not abort the ramp-down; the new target starts from IDLE.
- lock clears to 0 whenever tgt_q!=lock. A one-shot therefore retriggers only after the state leaves and re-enters.
- chan_en[cur-1]=1 in every non-IDLE state, including RAMP_DOWN. Channel switch is sequential, never overlapped.
- song_done is ignored outside PLAY and when cur=0.
- vol saturates: never exceeds VOL_MAX, never below 0.
- Timing: full ramp takes VOL_MAX*RAMP_DIV cycles.
- rst mid-ramp forces the reset values above immediately; no fade-out.

Decomposition:
- Package speaker_cue_pkg:
  - FSM state enum (IDLE, RAMP_UP, PLAY, RAMP_DOWN)
  - VOL_MAX function
  - a helper to convert a state code to one-hot
- Sub-module ramp_tick (parametrised RAMP_DIV prescaler with clear input and tick output). It is reused by other timed speaker blocks.

Test Plan:
All scenarios use N_STATES=4, VOL_W=4, RAMP_DIV=2, LOOP_MASK=3'b011.
- Reset: hold rst 3 cycles with state=1 -> all outputs 0 throughout. After release: restart at edge 2, chan_en=3'b001, vol reaches 15 after 30 cycles, busy drops.
- Switch mid-play: state 1->2 while in PLAY -> vol 15->0 over 30 cycles with chan_en=001. Then chan_en=000 for one cycle, restart pulses with chan_en=010, vol ramps 0->15.
- Loop vs one-shot:
  - state=1 in PLAY + song_done -> restart pulses, vol stays 15.
  - state=3 (one-shot) + song_done -> ramps to 0, stays IDLE while state=3. state 3->0->3 -> replays.
- Reversal mid-ramp-up: state=2, change to 0 at vol=7 -> ramp-down starts from 7, reaches 0 in 14 cycles, no vol step above 7.
- Out-of-range and ignored inputs:
  - Parametrised N_STATES=3 with state=3 -> treated as silence, chan_en=0.
  - song_done while IDLE -> no restart.
- Reset mid-ramp: assert rst at vol=9 -> next edge vol=0, chan_en=0, busy=0.
